mips16_ctrl: RTL

- Multi-cycle control FSM for the 16-bit MIPS-style datapath; the sender side of the ALU's 4-bit opcode interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU opcode, carry-in and operand select, plus the PC, IR, register-file and memory strobes.
- Consumes the ALU `eq` flag for BNE, and uses a req/ack handshake to a shared instruction/data memory.

---
 rtl/mips16_ctrl_if.sv | 24 ++
 rtl/mips16_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips16_ctrl_if.sv
// ALU opcode and shared-memory handshake bundle between mips16_ctrl (master)
// and the 16-bit datapath / memory (slave).
interface mips16_ctrl_if;
  logic [3:0] alu_opcod;
  logic       alu_cin;
  logic       alu_src_b;
  logic       alu_eq;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       mem_ack;

  modport master (
    output alu_opcod, alu_cin, alu_src_b,
    output mem_req, mem_we, mem_addr_sel,
    input  alu_eq, mem_ack
  );

  modport slave (
    input  alu_opcod, alu_cin, alu_src_b,
    input  mem_req, mem_we, mem_addr_sel,
    output alu_eq, mem_ack
  );
endinterface

// File: rtl/mips16_ctrl.sv
// Multi-cycle control FSM for the 16-bit MIPS-style datapath.
// Optional MIPS16_CTRL_PERF_EN adds retired-instruction and busy-cycle counters.
module mips16_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_i,
  input  logic [3:0]          ir_op_i,
  mips16_ctrl_if.master       bus,
  output logic [15:0]         pc_init_o,
  output logic                ir_we_o,
  output logic                pc_we_o,
  output logic                pc_src_o,
  output logic                reg_we_o,
  output logic                reg_dst_sel_o,
  output logic                wb_sel_o,
  output logic                busy_o,
  output logic                illegal_o
`ifdef MIPS16_CTRL_PERF_EN
  ,
  output logic [15:0]         retired_cnt_o,
  output logic [15:0]         cycle_cnt_o
`endif
);

  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM    = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_END    = 4'd9,
    ST_HALT   = 4'd10
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  function automatic logic is_rtype(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7: is_rtype = 1'b1;
      default:                      is_rtype = 1'b0;
    endcase
  endfunction

  function automatic logic is_memop(input logic [3:0] op);
    is_memop = (op == OP_LW) || (op == OP_SW);
  endfunction

  assign pc_init_o = RESET_PC;
  assign illegal_o = illegal_q;

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and Moore output decode (FETCH/MEM/BRANCH qualified by inputs).
  always_comb begin
    state_d          = state_q;
    illegal_d        = illegal_q;
    bus.alu_opcod    = 4'h0;
    bus.alu_cin      = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    ir_we_o          = 1'b0;
    pc_we_o          = 1'b0;
    pc_src_o         = 1'b0;
    reg_we_o         = 1'b0;
    reg_dst_sel_o    = 1'b0;
    wb_sel_o         = 1'b0;
    busy_o           = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (run_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (is_rtype(ir_op_i)) begin
          state_d = ST_EXEC_R;
        end else if (is_memop(ir_op_i)) begin
          state_d = ST_ADDR;
        end else if (ir_op_i == OP_BNE) begin
          state_d = ST_BRANCH;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end

      ST_EXEC_R: begin
        bus.alu_opcod = ir_op_i;
        bus.alu_cin   = (ir_op_i == OP_SUB);
        state_d       = ST_WB_R;
      end

      // ALU controls stay up so the result is still valid while it is written.
      ST_WB_R: begin
        bus.alu_opcod = ir_op_i;
        bus.alu_cin   = (ir_op_i == OP_SUB);
        reg_we_o      = 1'b1;
        reg_dst_sel_o = 1'b1;
        state_d       = ST_END;
      end

      ST_ADDR: begin
        bus.alu_opcod = ir_op_i;
        bus.alu_src_b = 1'b1;
        state_d       = ST_MEM;
      end

      ST_MEM: begin
        bus.alu_opcod    = ir_op_i;
        bus.alu_src_b    = 1'b1;
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (ir_op_i == OP_SW);
        if (bus.mem_ack) begin
          if (ir_op_i == OP_SW) begin
            state_d = ST_END;
          end else begin
            state_d = ST_WB_MEM;
          end
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB_MEM: begin
        reg_we_o = 1'b1;
        wb_sel_o = 1'b1;
        state_d  = ST_END;
      end

      // BNE: the ALU compares rs/rt; branch is taken when they differ.
      ST_BRANCH: begin
        bus.alu_opcod = OP_BNE;
        bus.alu_cin   = 1'b1;
        if (!bus.alu_eq) begin
          pc_we_o  = 1'b1;
          pc_src_o = 1'b1;
        end else begin
          pc_we_o  = 1'b0;
          pc_src_o = 1'b0;
        end
        state_d = ST_END;
      end

      ST_END: begin
        if (run_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        busy_o  = 1'b0;
        state_d = ST_HALT;
      end

      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MIPS16_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] cycle_q, cycle_d;

  // Counter next values; both wrap naturally at 16 bits.
  always_comb begin
    retired_d = retired_q;
    cycle_d   = cycle_q;
    if (state_q == ST_END) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
    if (busy_o) begin
      cycle_d = cycle_q + 16'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
      cycle_q   <= 16'h0000;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
    end
  end

  assign retired_cnt_o = retired_q;
  assign cycle_cnt_o   = cycle_q;
`endif

endmodule
